ps2_cmd_ctrl: RTL and testbench
===============================

Name: ps2_cmd_ctrl

Overview:
- Host-to-device PS/2 command sequencer; sits beside the PS/2 receive/decode path on the same kbclk/data lines.
- Accepts a command byte with an optional argument byte (e.g. 0xED + LED mask) and performs clock inhibit, request-to-send and bit transmission with parity.
- Checks the device line-ACK, then waits for the device response byte from the existing receive path: 0xFA (ACK) or 0xFE (RESEND).
- Reports completion or error to the requester.

Parameters:
- INHIBIT_CYC, 5000, clk cycles kbclk is held low before RTS (100 us at 50 MHz).
- TIMEOUT_CYC, 1000000, watchdog limit in clk cycles between line events or while waiting for a response.
- MAX_RETRY, 3, resends allowed per byte after 0xFE (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only; transfer occurs when cmd_valid && cmd_ready
- cmd_byte  in  8  command byte
- has_arg  in  1  an argument byte follows the command
- arg_byte  in  8  argument byte
- kbclk_i  in  1  raw PS/2 clock line (async)
- kbdata_i  in  1  raw PS/2 data line (async)
- kbclk_oe  out  1  1 = drive kbclk low (open-drain)
- kbdata_oe  out  1  1 = drive kbdata low
- rx_valid  in  1  one-cycle strobe from the receive path
- rx_byte  in  8  received scancode/response byte
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on success
- err  out  1  one-cycle pulse on failure
- err_code  out  2  0 none, 1 no line-ACK, 2 timeout, 3 device reject; held until next accepted command

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. Lines are released (oe=0) in the same cycle rst is sampled high, including mid-transfer. Retry count and pending argument are cleared.
- kbclk_i and kbdata_i each pass through a 2-FF synchronizer. Falling edge of kbclk = registered sync value 1 followed by current sync value 0 (2-3 clk latency).
- Latched on accept: cmd_byte, has_arg, arg_byte. The current transmit byte tx = cmd_byte.
- States and transitions:
  - IDLE: accept a command -> INHIBIT.
  - INHIBIT: kbclk_oe=1 for INHIBIT_CYC cycles -> RTS.
  - RTS: kbdata_oe=1 (start bit); kbclk_oe=0 on entry; bit counter n=0 -> SEND.
  - SEND: on each kbclk falling edge, n increments.
    - n=1..8: kbdata_oe = ~tx[n-1] (LSB first).
    - n=9: kbdata_oe = ~odd parity of tx.
    - n=10: kbdata_oe=0 (stop).
    - n=11: sample synced kbdata. 0 -> WAIT_RESP. 1 -> err, code 1.
  - WAIT_RESP: rx_valid with 0xFA -> if an argument is pending, tx = arg_byte and clear pending, -> INHIBIT; otherwise done -> IDLE. 0xFE -> see Optional Feature. Any other byte -> err, code 3.
- rx_valid outside WAIT_RESP is ignored. In WAIT_RESP only the first rx_valid counts.
- Watchdog: counter clears on every state entry and every kbclk falling edge, and is active in RTS/SEND/WAIT_RESP. Reaching TIMEOUT_CYC -> err, code 2, release lines, -> IDLE.
- Any error: lines released in the same cycle as the err pulse; returns to IDLE next cycle. done and err are never both high.
- cmd_valid while busy: no effect (cmd_ready=0).

Optional Feature:
- Macro PS2_CMD_RETRY_EN.
- Defined: on 0xFE in WAIT_RESP, if retry count < MAX_RETRY, increment it and resend the same tx byte (-> INHIBIT). Otherwise err, code 3. The retry count clears when a byte is ACKed.
- Undefined: 0xFE -> immediate err, code 3; no retry logic synthesized.

Test Plan:
- Command 0xF4, no argument; device model clocks 11 bits, pulls ACK low, returns 0xFA -> bits observed 0,0,1,0,1,1,1,1, parity 0; done pulse; err_code 0.
- Command 0xED with argument 0x07; device ACKs both -> two full frames (second: parity 0); single done after second 0xFA; busy high throughout.
- Device never clocks after RTS -> err with code 2 exactly TIMEOUT_CYC cycles after last event; kbclk_oe=kbdata_oe=0.
- ACK bit sampled high on edge 11 -> err, code 1; no wait for a response byte.
- 0xFE returned twice, then 0xFA, with PS2_CMD_RETRY_EN -> three identical frames, then done. Without the macro -> err, code 3 after first 0xFE.
- rst asserted during SEND at n=5 -> next cycle oe outputs 0, busy 0, cmd_ready 1; a new command then completes normally.

Source files
------------

// File: rtl/ps2_cmd_ctrl.sv
// ps2_cmd_ctrl: host-to-device PS/2 command sequencer.
// Sends a command byte and an optional argument byte to the device:
// clock inhibit, request-to-send, 11-bit frame, line-ACK check, then
// waits for 0xFA / 0xFE from the existing receive path.
// Optional build macro: PS2_CMD_RETRY_EN enables resending a byte after 0xFE
// (up to MAX_RETRY times per byte). Without it, 0xFE is a device reject.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | ready for a command, both lines released
// INHIBIT   | kbclk held low for INHIBIT_CYC cycles
// RTS       | kbclk released, kbdata held low as the start bit
// SEND      | data/parity/stop shifted on device falling edges, ACK on 11
// WAIT_RESP | waiting for the device response byte (0xFA / 0xFE)
module ps2_cmd_ctrl #(
   parameter int INHIBIT_CYC = 5000,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_byte,
   input  logic       has_arg,
   input  logic [7:0] arg_byte,
   input  logic       kbclk_i,
   input  logic       kbdata_i,
   output logic       kbclk_oe,
   output logic       kbdata_oe,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_INHIBIT = 3'd1;
   localparam logic [2:0] S_RTS     = 3'd2;
   localparam logic [2:0] S_SEND    = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;

   localparam logic [1:0] E_NO_ACK  = 2'd1;
   localparam logic [1:0] E_TIMEOUT = 2'd2;
   localparam logic [1:0] E_REJECT  = 2'd3;

   localparam logic [7:0] RSP_ACK    = 8'hFA;
   localparam logic [7:0] RSP_RESEND = 8'hFE;

   // Down-counters are loaded with N-1 and expire at terminal count zero,
   // so a phase lasts exactly N cycles.
   localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
   localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYC - 1);
   localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYC - 1);

`ifdef PS2_CMD_RETRY_EN
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
   logic [RTY_W-1:0] retry_cnt;
`endif

   logic [2:0]       state;
   logic [7:0]       tx;
   logic [7:0]       arg_q;
   logic             arg_pend;
   logic [3:0]       bit_n;
   logic [INH_W-1:0] inh_cnt;
   logic [WD_W-1:0]  wd_cnt;

   logic kbclk_m, kbclk_s, kbclk_d;
   logic kbdata_m, kbdata_s;
   logic kb_fall;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign kb_fall   = kbclk_d & ~kbclk_s;

   // Two-flop synchronizers for the raw lines plus one delay for edge detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         kbclk_m  <= 1'b1;
         kbclk_s  <= 1'b1;
         kbclk_d  <= 1'b1;
         kbdata_m <= 1'b1;
         kbdata_s <= 1'b1;
      end else begin
         kbclk_m  <= kbclk_i;
         kbclk_s  <= kbclk_m;
         kbclk_d  <= kbclk_s;
         kbdata_m <= kbdata_i;
         kbdata_s <= kbdata_m;
      end
   end

`ifdef PS2_CMD_RETRY_EN
   // Resend counter: cleared per accepted command and whenever a byte is ACKed.
   always_ff @(posedge clk) begin
      if (rst) begin
         retry_cnt <= '0;
      end else if (state == S_IDLE && cmd_valid) begin
         retry_cnt <= '0;
      end else if (state == S_WAIT && rx_valid) begin
         if (rx_byte == RSP_ACK) begin
            retry_cnt <= '0;
         end else if (rx_byte == RSP_RESEND && retry_cnt < RTY_MAX) begin
            retry_cnt <= retry_cnt + RTY_W'(1);
         end
      end
   end
`endif

   // Sequencer: line drive, bit counter, timers and completion reporting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         kbclk_oe  <= 1'b0;
         kbdata_oe <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'd0;
         tx        <= 8'h00;
         arg_q     <= 8'h00;
         arg_pend  <= 1'b0;
         bit_n     <= 4'd0;
         inh_cnt   <= '0;
         wd_cnt    <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  tx        <= cmd_byte;
                  arg_q     <= arg_byte;
                  arg_pend  <= has_arg;
                  err_code  <= 2'd0;
                  inh_cnt   <= INH_LOAD;
                  kbclk_oe  <= 1'b1;
                  kbdata_oe <= 1'b0;
                  state     <= S_INHIBIT;
               end
            end

            S_INHIBIT: begin
               if (inh_cnt == '0) begin
                  kbclk_oe  <= 1'b0;
                  kbdata_oe <= 1'b1;
                  bit_n     <= 4'd0;
                  wd_cnt    <= WD_LOAD;
                  state     <= S_RTS;
               end else begin
                  inh_cnt <= inh_cnt - INH_W'(1);
               end
            end

            S_RTS: begin
               wd_cnt <= WD_LOAD;
               state  <= S_SEND;
            end

            S_SEND: begin
               if (kb_fall) begin
                  // bit_n holds the number of edges seen before this one.
                  bit_n  <= bit_n + 4'd1;
                  wd_cnt <= WD_LOAD;
                  if (bit_n < 4'd8) begin
                     kbdata_oe <= ~tx[bit_n[2:0]];
                  end else if (bit_n == 4'd8) begin
                     // Odd parity bit is ~^tx; the line is driven low for a 0.
                     kbdata_oe <= ^tx;
                  end else if (bit_n == 4'd9) begin
                     kbdata_oe <= 1'b0;
                  end else if (!kbdata_s) begin
                     state <= S_WAIT;
                  end else begin
                     err       <= 1'b1;
                     err_code  <= E_NO_ACK;
                     kbclk_oe  <= 1'b0;
                     kbdata_oe <= 1'b0;
                     arg_pend  <= 1'b0;
                     state     <= S_IDLE;
                  end
               end else if (wd_cnt == '0) begin
                  err       <= 1'b1;
                  err_code  <= E_TIMEOUT;
                  kbclk_oe  <= 1'b0;
                  kbdata_oe <= 1'b0;
                  arg_pend  <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  wd_cnt <= wd_cnt - WD_W'(1);
               end
            end

            S_WAIT: begin
               if (rx_valid) begin
                  if (rx_byte == RSP_ACK) begin
                     if (arg_pend) begin
                        tx        <= arg_q;
                        arg_pend  <= 1'b0;
                        inh_cnt   <= INH_LOAD;
                        kbclk_oe  <= 1'b1;
                        kbdata_oe <= 1'b0;
                        state     <= S_INHIBIT;
                     end else begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                     end
`ifdef PS2_CMD_RETRY_EN
                  end else if (rx_byte == RSP_RESEND && retry_cnt < RTY_MAX) begin
                     inh_cnt   <= INH_LOAD;
                     kbclk_oe  <= 1'b1;
                     kbdata_oe <= 1'b0;
                     state     <= S_INHIBIT;
`endif
                  end else begin
                     err       <= 1'b1;
                     err_code  <= E_REJECT;
                     kbclk_oe  <= 1'b0;
                     kbdata_oe <= 1'b0;
                     arg_pend  <= 1'b0;
                     state     <= S_IDLE;
                  end
               end else if (wd_cnt == '0) begin
                  err       <= 1'b1;
                  err_code  <= E_TIMEOUT;
                  kbclk_oe  <= 1'b0;
                  kbdata_oe <= 1'b0;
                  arg_pend  <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  wd_cnt <= wd_cnt - WD_W'(1);
               end
            end

            default: begin
               kbclk_oe  <= 1'b0;
               kbdata_oe <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// tb_ps2_cmd_ctrl: directed bench for ps2_cmd_ctrl with a PS/2 device model.
// Expected frames and expected outcomes are queued when stimulus is issued
// and popped when the device model captures a frame or the DUT reports.
module tb_ps2_cmd_ctrl;

   localparam int INH = 20;
   localparam int TMO = 300;
   localparam int P   = 6;

   localparam logic [1:0] K_DONE = 2'b01;
   localparam logic [1:0] K_ERR  = 2'b10;

   typedef struct {
      logic       done;
      logic       err;
      logic [1:0] code;
      logic       lines;
      time        t;
   } obs_t;

   typedef struct {
      logic [1:0] kind;
      logic [1:0] code;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_byte;
   logic       has_arg;
   logic [7:0] arg_byte;
   logic       kbclk_i;
   logic       kbdata_i;
   logic       kbclk_oe;
   logic       kbdata_oe;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   logic dev_clk;
   logic dev_data;

   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   busy_low_cnt = 0;
   bit   track_busy = 1'b0;
   time  fall11_t = 0;

   obs_t       obs_q[$];
   exp_t       exp_q[$];
   logic [7:0] exp_tx[$];

   always #5 clk = ~clk;

   // Open-drain wiring: either side can pull a line low.
   assign kbclk_i  = dev_clk & ~kbclk_oe;
   assign kbdata_i = dev_data & ~kbdata_oe;

   ps2_cmd_ctrl #(
      .INHIBIT_CYC(INH),
      .TIMEOUT_CYC(TMO),
      .MAX_RETRY(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_byte(cmd_byte),
      .has_arg(has_arg),
      .arg_byte(arg_byte),
      .kbclk_i(kbclk_i),
      .kbdata_i(kbdata_i),
      .kbclk_oe(kbclk_oe),
      .kbdata_oe(kbdata_oe),
      .rx_valid(rx_valid),
      .rx_byte(rx_byte),
      .busy(busy),
      .done(done),
      .err(err),
      .err_code(err_code)
   );

   // Output monitor: records every completion/error pulse with its context.
   always @(negedge clk) begin
      if (done === 1'b1 || err === 1'b1)
         obs_q.push_back('{done, err, err_code, kbclk_oe | kbdata_oe, $time});
      if (done === 1'b1) done_cnt++;
      if (track_busy && busy !== 1'b1) busy_low_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_res(input logic [1:0] kind, input logic [1:0] code);
      exp_q.push_back('{kind, code});
   endtask

   task automatic send_cmd(input logic [7:0] c, input logic h, input logic [7:0] a);
      cmd_byte  = c;
      has_arg   = h;
      arg_byte  = a;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
   endtask

   task automatic wait_rts(input bit chk_inh, output time rts_t);
      int t;
      int inh;
      t   = 0;
      inh = 0;
      while (!(kbclk_oe === 1'b0 && kbdata_oe === 1'b1) && t < 5000) begin
         if (kbclk_oe === 1'b1) inh++;
         @(negedge clk);
         t++;
      end
      check("rts_reached", t < 5000, 1);
      if (chk_inh) check("inhibit_cycles", inh, INH);
      check("start_bit", kbdata_i, 0);
      rts_t = $time;
   endtask

   // Device model: clocks n_edges bits, samples the line on rising edges,
   // drives the line-ACK value before the 11th falling edge.
   task automatic dev_frame(input int n_edges, input logic ack_bit, input bit chk_inh);
      logic [9:0] bits;
      logic [7:0] e;
      time        rts_t;
      int         ones;
      bits = '0;
      wait_rts(chk_inh, rts_t);
      for (int k = 1; k <= n_edges; k++) begin
         if (k == 11) dev_data = ack_bit;
         repeat (P) @(negedge clk);
         dev_clk = 1'b0;
         if (k == 11) fall11_t = $time;
         repeat (P) @(negedge clk);
         dev_clk = 1'b1;
         if (k <= 10) bits[k-1] = kbdata_i;
         if (k == 11) dev_data = 1'b1;
      end
      if (n_edges == 11) begin
         check("tx_queue_nonempty", exp_tx.size() != 0, 1);
         if (exp_tx.size() != 0) e = exp_tx.pop_front();
         else e = 8'h00;
         ones = 0;
         for (int i = 0; i < 8; i++) ones += int'(e[i]);
         check("frame_data", bits[7:0], e);
         check("frame_parity", bits[8], (ones % 2 == 0) ? 1 : 0);
         check("frame_stop", bits[9], 1);
      end
   endtask

   task automatic expect_result(input int limit, output time t_ev);
      obs_t o;
      exp_t e;
      int   t;
      t = 0;
      while (obs_q.size() == 0 && t < limit) begin
         @(negedge clk);
         t++;
      end
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
         o = '{1'b0, 1'b0, 2'd0, 1'b0, $time};
      end else begin
         o = obs_q.pop_front();
      end
      check("result_kind", {o.err, o.done}, e.kind);
      check("err_code", o.code, e.code);
      check("lines_released", o.lines, 0);
      t_ev = o.t;
   endtask

   initial begin
      time tev;
      time rts_t;
      int  d0;

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_byte  = 8'h00;
      has_arg   = 1'b0;
      arg_byte  = 8'h00;
      rx_valid  = 1'b0;
      rx_byte   = 8'h00;
      dev_clk   = 1'b1;
      dev_data  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_kbclk_oe", kbclk_oe, 0);
      check("rst_kbdata_oe", kbdata_oe, 0);
      check("rst_done_err", {done, err}, 0);
      check("rst_err_code", err_code, 0);
      rst = 1'b0;
      @(negedge clk);

      // 0xF4, no argument.
      exp_tx.push_back(8'hF4);
      push_res(K_DONE, 2'd0);
      send_cmd(8'hF4, 1'b0, 8'h00);
      dev_frame(11, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      send_rx(8'hFA);
      expect_result(50, tev);

      // 0xED + 0x07: two frames, one done, busy throughout, cmd_valid ignored.
      exp_tx.push_back(8'hED);
      exp_tx.push_back(8'h07);
      push_res(K_DONE, 2'd0);
      d0 = done_cnt;
      send_cmd(8'hED, 1'b1, 8'h07);
      busy_low_cnt = 0;
      track_busy   = 1'b1;
      cmd_valid    = 1'b1;
      cmd_byte     = 8'h55;
      has_arg      = 1'b0;
      dev_frame(11, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      send_rx(8'hFA);
      dev_frame(11, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      cmd_valid  = 1'b0;
      track_busy = 1'b0;
      send_rx(8'hFA);
      expect_result(50, tev);
      check("busy_low_cycles", busy_low_cnt, 0);
      check("done_pulses", done_cnt - d0, 1);

      // Device never clocks: timeout counted from SEND entry, one cycle after RTS.
      push_res(K_ERR, 2'd2);
      send_cmd(8'hF4, 1'b0, 8'h00);
      wait_rts(1'b1, rts_t);
      expect_result(TMO + 50, tev);
      check("timeout_cycles", int'((tev - rts_t) / 10), TMO + 1);

      // Line-ACK sampled high on edge 11.
      exp_tx.push_back(8'hF4);
      push_res(K_ERR, 2'd1);
      send_cmd(8'hF4, 1'b0, 8'h00);
      dev_frame(11, 1'b1, 1'b1);
      expect_result(20, tev);
      check("nack_latency_ok", int'((tev - fall11_t) / 10) <= 5, 1);

      // Stray rx_valid during INHIBIT ignored; unknown response is a reject.
      exp_tx.push_back(8'h0F);
      push_res(K_ERR, 2'd3);
      send_cmd(8'h0F, 1'b0, 8'h00);
      send_rx(8'hFA);
      dev_frame(11, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      send_rx(8'hAA);
      expect_result(50, tev);

      // 0xFE handling.
      exp_tx.push_back(8'hF3);
`ifdef PS2_CMD_RETRY_EN
      push_res(K_DONE, 2'd0);
      send_cmd(8'hF3, 1'b0, 8'h00);
      dev_frame(11, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      exp_tx.push_back(8'hF3);
      send_rx(8'hFE);
      dev_frame(11, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      exp_tx.push_back(8'hF3);
      send_rx(8'hFE);
      dev_frame(11, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      send_rx(8'hFA);
      expect_result(50, tev);
`else
      push_res(K_ERR, 2'd3);
      send_cmd(8'hF3, 1'b0, 8'h00);
      dev_frame(11, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      send_rx(8'hFE);
      expect_result(50, tev);
`endif

      // Reset during SEND after five edges, then a normal command.
      send_cmd(8'hED, 1'b1, 8'h07);
      dev_frame(5, 1'b0, 1'b1);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_kbclk_oe", kbclk_oe, 0);
      check("mid_rst_kbdata_oe", kbdata_oe, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_cmd_ready", cmd_ready, 1);
      check("mid_rst_done_err", {done, err}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_no_result", obs_q.size(), 0);
      exp_tx.push_back(8'hF4);
      push_res(K_DONE, 2'd0);
      send_cmd(8'hF4, 1'b0, 8'h00);
      dev_frame(11, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      send_rx(8'hFA);
      expect_result(50, tev);
      check("final_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
